// File: rtl/tank_pkg.sv
// rtl/tank_pkg.sv - shared channel state type and constants for the projectile timer bank
package tank_pkg;

  typedef enum logic [1:0] {
    PT_IDLE,
    PT_FLY,
    PT_DONE
  } pt_state_t;

  localparam int BOUNCE_W = 4;

endpackage

// File: rtl/proj_timer_channel.sv
// rtl/proj_timer_channel.sv - one bullet's flight timer (FSM, prescaler, total, segment time, bounces); expiry under PROJ_TIMER_EXPIRE_EN
module proj_timer_channel
  import tank_pkg::*;
#(
  parameter int TW        = 16,
  parameter int PRESCALE  = 3,
  parameter int MAX_TICKS = 255
) (
  input  logic                frame_clk,
  input  logic                Reset,
  input  logic                active,
  input  logic                bounce,
  output logic [TW-1:0]       time_out,
  output logic                tick,
  output logic [BOUNCE_W-1:0] bounces,
  output logic                expired
);

  localparam int PW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int TOT_W = (MAX_TICKS > 1) ? $clog2(MAX_TICKS + 1) : 1;

  localparam logic [PW-1:0]       PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [TW-1:0]       TIME_MAX   = '1;
  localparam logic [TOT_W-1:0]    TOT_MAX    = '1;
  localparam logic [BOUNCE_W-1:0] BNC_MAX    = '1;

  pt_state_t           state_q, state_d;
  logic [PW-1:0]       presc_q, presc_d;
  logic [TOT_W-1:0]    total_q, total_d;
  logic [TW-1:0]       time_q, time_d;
  logic [BOUNCE_W-1:0] bounces_q, bounces_d;
  logic                tick_q, tick_d;
  logic                expired_q, expired_d;

  // Next-state logic; IDLE keeps every register at zero, so the launch frame
  // sees presc==0 and naturally becomes the first tick frame.
  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    total_d   = total_q;
    time_d    = time_q;
    bounces_d = bounces_q;
    tick_d    = 1'b0;
    expired_d = 1'b0;

    case (state_q)
      PT_IDLE, PT_FLY: begin
        if (!active) begin
          state_d   = PT_IDLE;
          presc_d   = '0;
          total_d   = '0;
          time_d    = '0;
          bounces_d = '0;
        end else begin
          state_d = PT_FLY;
          presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
          if (presc_q == '0) begin
            tick_d  = 1'b1;
            total_d = (total_q == TOT_MAX) ? total_q : total_q + 1'b1;
            if (bounce) begin
              time_d    = TW'(1);
              bounces_d = (bounces_q == BNC_MAX) ? bounces_q : bounces_q + 1'b1;
            end else begin
              time_d = (time_q == TIME_MAX) ? time_q : time_q + 1'b1;
            end
`ifdef PROJ_TIMER_EXPIRE_EN
            if (({1'b0, total_q} + 1'b1) == (TOT_W + 1)'(MAX_TICKS)) begin
              expired_d = 1'b1;
              state_d   = PT_DONE;
            end
`endif
          end
        end
      end
`ifdef PROJ_TIMER_EXPIRE_EN
      PT_DONE: begin
        if (!active) begin
          state_d   = PT_IDLE;
          presc_d   = '0;
          total_d   = '0;
          time_d    = '0;
          bounces_d = '0;
        end
      end
`endif
      default: begin
        state_d   = PT_IDLE;
        presc_d   = '0;
        total_d   = '0;
        time_d    = '0;
        bounces_d = '0;
      end
    endcase
  end

  // Channel registers; Reset overrides everything and parks the channel in IDLE.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q   <= PT_IDLE;
      presc_q   <= '0;
      total_q   <= '0;
      time_q    <= '0;
      bounces_q <= '0;
      tick_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      total_q   <= total_d;
      time_q    <= time_d;
      bounces_q <= bounces_d;
      tick_q    <= tick_d;
      expired_q <= expired_d;
    end
  end

  assign time_out = time_q;
  assign tick     = tick_q;
  assign bounces  = bounces_q;
  assign expired  = expired_q;

endmodule

// File: rtl/projectile_timer_bank.sv
// rtl/projectile_timer_bank.sv - bank of independent projectile flight timers; optional expiry via PROJ_TIMER_EXPIRE_EN
module projectile_timer_bank
  import tank_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int TW        = 16,
  parameter int PRESCALE  = 3,
  parameter int MAX_TICKS = 255
) (
  input  logic                         frame_clk,
  input  logic                         Reset,
  input  logic [NUM_CH-1:0]            active,
  input  logic [NUM_CH-1:0]            bounce,
  output logic [NUM_CH*TW-1:0]         time_out,
  output logic [NUM_CH-1:0]            tick,
  output logic [NUM_CH*BOUNCE_W-1:0]   bounces,
  output logic [NUM_CH-1:0]            expired
);

  // One self-contained timer per bullet; the top only slices the packed buses.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    proj_timer_channel #(
      .TW        (TW),
      .PRESCALE  (PRESCALE),
      .MAX_TICKS (MAX_TICKS)
    ) u_ch (
      .frame_clk (frame_clk),
      .Reset     (Reset),
      .active    (active[i]),
      .bounce    (bounce[i]),
      .time_out  (time_out[i*TW +: TW]),
      .tick      (tick[i]),
      .bounces   (bounces[i*BOUNCE_W +: BOUNCE_W]),
      .expired   (expired[i])
    );
  end

endmodule

// File: tb/tb_projectile_timer_bank.sv
// tb/tb_projectile_timer_bank.sv - scoreboard bench for projectile_timer_bank; honours PROJ_TIMER_EXPIRE_EN
`timescale 1ns/1ps
module tb_projectile_timer_bank;
  import tank_pkg::*;

`ifdef PROJ_TIMER_EXPIRE_EN
  localparam int TW_B   = 3;
  localparam bit EXP_EN = 1'b1;
`else
  localparam int TW_B   = 2;
  localparam bit EXP_EN = 1'b0;
`endif
  localparam int TW_A  = 16;
  localparam int PS_A  = 3;
  localparam int MAX_A = 255;
  localparam int PS_B  = 1;
  localparam int MAX_B = 4;

  logic            frame_clk = 1'b0;
  logic            Reset;
  logic [1:0]      active_a, bounce_a, tick_a, expired_a;
  logic [31:0]     time_a;
  logic [7:0]      bounces_a;
  logic [0:0]      active_b, bounce_b, tick_b, expired_b;
  logic [TW_B-1:0] time_b;
  logic [3:0]      bounces_b;

  always #5 frame_clk = ~frame_clk;

  projectile_timer_bank #(
    .NUM_CH(2), .TW(TW_A), .PRESCALE(PS_A), .MAX_TICKS(MAX_A)
  ) dut_a (
    .frame_clk(frame_clk), .Reset(Reset), .active(active_a), .bounce(bounce_a),
    .time_out(time_a), .tick(tick_a), .bounces(bounces_a), .expired(expired_a)
  );

  projectile_timer_bank #(
    .NUM_CH(1), .TW(TW_B), .PRESCALE(PS_B), .MAX_TICKS(MAX_B)
  ) dut_b (
    .frame_clk(frame_clk), .Reset(Reset), .active(active_b), .bounce(bounce_b),
    .time_out(time_b), .tick(tick_b), .bounces(bounces_b), .expired(expired_b)
  );

  typedef struct packed {
    logic [2:0][15:0] t;
    logic [2:0]       k;
    logic [2:0][3:0]  b;
    logic [2:0]       x;
  } exp_t;

  exp_t sb_q[$];

  int total_cnt = 0;
  int bad_cnt   = 0;

  int m_frame[3], m_time[3], m_bnc[3], m_total[3];
  bit m_done[3], m_tick[3], m_exp[3];
  int ps_c[3]  = '{PS_A, PS_A, PS_B};
  int tw_c[3]  = '{TW_A, TW_A, TW_B};
  int max_c[3] = '{MAX_A, MAX_A, MAX_B};

  int seq1[7]  = '{1, 1, 1, 2, 2, 2, 3};
  int tk1[7]   = '{1, 0, 0, 1, 0, 0, 1};
`ifdef PROJ_TIMER_EXPIRE_EN
  int seqb[7]  = '{1, 2, 3, 4, 4, 4, 4};
  int expb[7]  = '{0, 0, 0, 1, 0, 0, 0};
`else
  int seqb[7]  = '{1, 2, 3, 3, 3, 3, 3};
`endif

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    total_cnt++;
    if (got !== want) begin
      bad_cnt++;
      $display("FAIL %s: got=%0d want=%0d at %0t", tag, got, want, $time);
    end
  endtask

  // Behavioural model: frames counted from launch; frame n ticks when n % P == 0.
  task automatic model_ch(input int c, input bit act, input bit bnc);
    int tmax;
    tmax = (1 << tw_c[c]) - 1;
    m_tick[c] = 1'b0;
    m_exp[c]  = 1'b0;
    if (Reset || !act) begin
      m_frame[c] = 0; m_time[c] = 0; m_bnc[c] = 0; m_total[c] = 0; m_done[c] = 1'b0;
    end else if (!m_done[c]) begin
      if ((m_frame[c] % ps_c[c]) == 0) begin
        m_tick[c] = 1'b1;
        m_total[c]++;
        if (bnc) begin
          m_time[c] = 1;
          if (m_bnc[c] < 15) m_bnc[c]++;
        end else if (m_time[c] < tmax) begin
          m_time[c]++;
        end
        if (EXP_EN && m_total[c] == max_c[c]) begin
          m_exp[c]  = 1'b1;
          m_done[c] = 1'b1;
        end
      end
      m_frame[c]++;
    end
  endtask

  task automatic step();
    exp_t e;
    bit act[3], bnc[3];
    act[0] = active_a[0]; act[1] = active_a[1]; act[2] = active_b[0];
    bnc[0] = bounce_a[0]; bnc[1] = bounce_a[1]; bnc[2] = bounce_b[0];
    for (int c = 0; c < 3; c++) begin
      model_ch(c, act[c], bnc[c]);
      e.t[c] = 16'(m_time[c]);
      e.k[c] = m_tick[c];
      e.b[c] = 4'(m_bnc[c]);
      e.x[c] = m_exp[c];
    end
    sb_q.push_back(e);
    @(posedge frame_clk);
    #1;
    e = sb_q.pop_front();
    for (int c = 0; c < 2; c++) begin
      check_eq($sformatf("time%0d", c),    32'(time_a[c*16 +: 16]),  32'(e.t[c]));
      check_eq($sformatf("tick%0d", c),    32'(tick_a[c]),           32'(e.k[c]));
      check_eq($sformatf("bounces%0d", c), 32'(bounces_a[c*4 +: 4]), 32'(e.b[c]));
      check_eq($sformatf("expired%0d", c), 32'(expired_a[c]),        32'(e.x[c]));
    end
    check_eq("time_b",    32'(time_b),     32'(e.t[2]));
    check_eq("tick_b",    32'(tick_b),     32'(e.k[2]));
    check_eq("bounces_b", 32'(bounces_b),  32'(e.b[2]));
    check_eq("expired_b", 32'(expired_b),  32'(e.x[2]));
  endtask

  initial begin
    Reset    = 1'b1;
    active_a = '0; bounce_a = '0;
    active_b = '0; bounce_b = '0;
    repeat (2) step();
    check_eq("rst_time0", 32'(time_a[15:0]), 32'd0);
    Reset = 1'b0;

    active_a[0] = 1'b1;
    active_b[0] = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      check_eq("t1_time", 32'(time_a[15:0]), 32'(seq1[i]));
      check_eq("t1_tick", 32'(tick_a[0]),    32'(tk1[i]));
      check_eq("tb_time", 32'(time_b),       32'(seqb[i]));
`ifdef PROJ_TIMER_EXPIRE_EN
      check_eq("tb_expired", 32'(expired_b), 32'(expb[i]));
`endif
    end

    repeat (6) step();
    check_eq("t2_time5", 32'(time_a[15:0]), 32'd5);
    bounce_a[0] = 1'b1;
    step();
    check_eq("t2_nontick_time", 32'(time_a[15:0]), 32'd5);
    check_eq("t2_nontick_bnc",  32'(bounces_a[3:0]), 32'd0);
    bounce_a[0] = 1'b0;
    step();
    bounce_a[0] = 1'b1;
    step();
    check_eq("t2_bounce_time", 32'(time_a[15:0]),   32'd1);
    check_eq("t2_bounce_cnt",  32'(bounces_a[3:0]), 32'd1);
    bounce_a[0] = 1'b0;

    active_b[0] = 1'b0;
    active_a[0] = 1'b0;
    step();
    check_eq("t5_time0",  32'(time_a[15:0]),   32'd0);
    check_eq("t5_bnc0",   32'(bounces_a[3:0]), 32'd0);
    check_eq("tb_idle",   32'(time_b),         32'd0);
    active_a[0] = 1'b1;
    step();
    check_eq("t5_restart", 32'(time_a[15:0]), 32'd1);
    step();
    active_a[1] = 1'b1;
    active_b[0] = 1'b1;
    for (int i = 0; i < 24; i++) begin
      bounce_a = 2'($urandom_range(0, 3));
      step();
    end
    bounce_a = '0;

    Reset = 1'b1;
    step();
    check_eq("t4_rst_time", 32'(time_a),  32'd0);
    check_eq("t4_rst_tick", 32'(tick_a),  32'd0);
    Reset = 1'b0;
    step();
    check_eq("t4_post_time0", 32'(time_a[15:0]),  32'd1);
    check_eq("t4_post_time1", 32'(time_a[31:16]), 32'd1);
    check_eq("t4_post_tick",  32'(tick_a),        32'd3);

    for (int i = 0; i < 400; i++) begin
      active_a[0] = ($urandom_range(0, 7) != 0);
      active_a[1] = ($urandom_range(0, 7) != 0);
      active_b[0] = ($urandom_range(0, 9) != 0);
      bounce_a    = 2'($urandom_range(0, 3));
      bounce_b[0] = ($urandom_range(0, 3) == 0);
      Reset       = ($urandom_range(0, 59) == 0);
      step();
    end
    Reset = 1'b0;

    check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
